// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Latency: none (declarations only).
// Backpressure: not applicable.
package bin2bcd_pkg;

   // Converter control states: waiting for input, shifting bits, holding result.
   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Code driven onto a blanked leading digit; the 7-segment decoder shows nothing for it.
   localparam logic [3:0] BCD_BLANK = 4'hF;

   // Bits per BCD digit.
   localparam int BCD_W = 4;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more.
// Latency: combinational.
// Backpressure: not applicable.
module bcd_add3 (
   input  logic [3:0] d,
   output logic [3:0] q
);

   // A digit of 5..9 becomes 8..12, so the following shift carries into the next digit.
   assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// Latency: out_valid rises BIN_W clocks after the accept edge; accepts are at least BIN_W+2 clocks apart.
// Backpressure: holds the result in DONE while out_ready=0; in_ready only in IDLE.
// Option: define BIN2BCD_LZ_BLANK_EN to replace leading zero digits (never digit 0) with 4'hF.
module bin_to_bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [BIN_W-1:0]          in_bin,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [BCD_W*DIGITS-1:0]   out_bcd,
   output logic                      ovf
);

   localparam int BCD_TW = BCD_W * DIGITS;
   localparam int CNT_W  = $clog2(BIN_W + 1);

   state_t              state;
   logic [BIN_W-1:0]    sr;
   logic [BCD_TW-1:0]   acc;
   logic [BCD_TW-1:0]   acc_corr;
   logic [BCD_TW-1:0]   acc_nxt;
   logic [BCD_TW-1:0]   bcd_fin;
   logic [BCD_TW-1:0]   bcd_q;
   logic [CNT_W-1:0]    cnt;
   logic                ovf_q;
   logic                vld_q;

   // One corrector per digit; digits are corrected independently with no carry between them.
   genvar g;
   for (g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d (acc[g*BCD_W +: BCD_W]),
         .q (acc_corr[g*BCD_W +: BCD_W])
      );
   end

   // Corrected accumulator shifted left, taking in the next binary bit at the bottom.
   assign acc_nxt = {acc_corr[BCD_TW-2:0], sr[BIN_W-1]};

`ifdef BIN2BCD_LZ_BLANK_EN
   logic lead;

   // Blank leading zero digits above digit 0 on the value about to be presented.
   always_comb begin
      bcd_fin = acc_nxt;
      lead    = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (lead && (acc_nxt[i*BCD_W +: BCD_W] == 4'd0)) begin
            bcd_fin[i*BCD_W +: BCD_W] = BCD_BLANK;
         end else begin
            lead = 1'b0;
         end
      end
   end
`else
   assign bcd_fin = acc_nxt;
`endif

   // Control FSM together with the datapath registers and the registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         vld_q <= 1'b0;
         bcd_q <= '0;
         ovf_q <= 1'b0;
         sr    <= '0;
         acc   <= '0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sr    <= in_bin;
                  acc   <= '0;
                  ovf_q <= 1'b0;
                  cnt   <= CNT_W'(BIN_W);
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               acc <= acc_nxt;
               sr  <= sr << 1;
               // A bit leaving the top digit means the value needs more digits than we have.
               if (acc_corr[BCD_TW-1]) begin
                  ovf_q <= 1'b1;
               end
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1)) begin
                  state <= DONE;
                  vld_q <= 1'b1;
                  bcd_q <= bcd_fin;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
                  vld_q <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               vld_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = (state == IDLE) && !rst;
   assign out_valid = vld_q;
   assign out_bcd   = bcd_q;
   // Overflow flag is only meaningful alongside a presented result.
   assign ovf       = ovf_q && vld_q;

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter using iterative double-dabble, one shift per clock. It sits directly upstream of the BCD-to-7-segment decoder. It turns a binary count or measurement into DIGITS packed BCD nibbles, and each nibble feeds one decoder instance. Valid/ready handshakes on both sides allow stalling by either the producer or the display path.

## Interface
- BIN_W, default 8: width of the binary input, from 1 to 32.
- DIGITS, default 3: number of BCD output digits, from 1 to 10.
- clk  input  1: the single clock. All logic updates on its rising edge.
- rst  input  1: synchronous, active-high reset.
- in_valid  input  1: in_bin is valid.
- in_ready  output  1: the block can accept a new value.
- in_bin  input  BIN_W: binary value to convert, unsigned.
- out_valid  output  1: out_bcd holds a completed result.
- out_ready  input  1: the consumer accepts out_bcd.
- out_bcd  output  4*DIGITS: packed BCD. Digit 0 (the units digit) is bits [3:0].
- ovf  output  1: the input was at least 10^DIGITS. Valid while out_valid is high.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - in_ready=1.
  - When in_valid&&in_ready: load the shift register with in_bin, clear the BCD accumulator and ovf, set bit counter=BIN_W, go to SHIFT.
- SHIFT, each cycle:
  - Every digit ≥5 gets +3 (4-bit arithmetic, no carry between digits).
  - Then {accumulator, shift register} shifts left by 1.
  - If the bit shifted out of the top digit is 1, ovf sets and stays set (sticky).
  - Decrement the counter. When the counter reaches 1, go to DONE on this edge.
- DONE
  - out_valid=1. out_bcd and ovf are held stable.
  - When out_ready=1, go to IDLE.
- in_ready is 1 only in IDLE and only when rst=0. There is no overlap between DONE and accepting the next value.
- in_bin is sampled only on the accept edge. Later changes to in_bin have no effect.
- Overflow behaviour: out_bcd = in_bin mod 10^DIGITS, and ovf=1.
  - ovf is combinationally 0 whenever out_valid=0.
- Reset can arrive in any state, including mid-SHIFT. The next state is IDLE and the partial result is discarded.

## Timing
- Reset values: state=IDLE, out_valid=0, out_bcd=0, ovf=0. in_ready reads 0 while rst=1 and 1 on the first cycle after rst deasserts.
- Latency: if the value is accepted at edge E0, out_valid rises at edge E0+BIN_W.
- Minimum spacing between accepts is BIN_W+2 cycles: BIN_W shifts, 1 DONE cycle with out_ready=1, then 1 IDLE cycle.
- Backpressure: while out_ready=0, DONE holds with no bound. out_bcd, ovf and out_valid stay unchanged.
- Outputs are registered.
- Critical path: one add-3 corrector plus the shift mux per digit. This is independent of DIGITS.

## Configuration
- Macro: BIN2BCD_LZ_BLANK_EN.
- When the macro is defined, leading zero digits are replaced with 4'hF on out_bcd. The downstream decoder blanks codes 10–15, so those digits go dark.
  - Blanking is applied at the DONE transition and never affects digit 0.
  - Example: 7 with DIGITS=3 → 0xFF7.
  - ovf, handshake and latency are unchanged.
- When the macro is undefined, out_bcd is always plain BCD with leading zeros shown (0x007).

## Structure
- Package bin2bcd_pkg contains:
  - the state enum (IDLE, SHIFT, DONE);
  - the constant BCD_BLANK = 4'hF;
  - the constant BCD_W = 4.
- Sub-module bcd_add3: a combinational 4-bit "if ≥5 then +3" corrector, instantiated DIGITS times in a generate loop.
- The top level holds the FSM, the bit counter (width $clog2(BIN_W+1)), the shift register, the accumulator, ovf and the blanking logic.

## Test plan
- BIN_W=8, DIGITS=3, in_bin=255, out_ready=1 → out_valid exactly 8 cycles after accept, out_bcd=0x255, ovf=0.
- in_bin=0 → out_bcd=0x000. With BIN2BCD_LZ_BLANK_EN: 0xFF0. Also in_bin=40 with the macro → 0xF40.
- DIGITS=2, in_bin=200 → out_bcd=0x00, ovf=1. Also in_bin=99 → 0x99, ovf=0.
- Hold out_ready=0 for 20 cycles after a result of 0x128 → out_bcd stable, in_ready=0 throughout, then one IDLE cycle after out_ready=1.
- Assert rst on the 4th SHIFT cycle of a conversion → next cycle IDLE, out_valid=0, out_bcd=0. A new conversion of 93 then returns 0x093.
- Back-to-back producer with in_valid held high and values 1, 2, 3 → three results in order, accepts spaced exactly 10 cycles apart.
